// File: rtl/wb_fetch_responder_if.sv
// wb_fetch_responder_if
//   Pipelined Wishbone bundle between a fetch initiator (master) and the
//   wb_fetch_responder (slave). Clock and reset are not part of the bundle.
//   Signals:
//     i_wb_cyc, i_wb_stb, i_wb_we  request qualifiers   (master -> slave)
//     i_wb_addr [AW]               word address         (master -> slave)
//     i_wb_data [DW], i_wb_sel     write data / selects (master -> slave)
//     o_wb_stall                   request not accepted (slave -> master)
//     o_wb_ack, o_wb_err           response strobes     (slave -> master)
//     o_wb_data [DW]               read data            (slave -> master)
interface wb_fetch_responder_if #(
   parameter int AW = 28,
   parameter int DW = 32
);
   logic            i_wb_cyc;
   logic            i_wb_stb;
   logic            i_wb_we;
   logic [AW-1:0]   i_wb_addr;
   logic [DW-1:0]   i_wb_data;
   logic [DW/8-1:0] i_wb_sel;
   logic            o_wb_stall;
   logic            o_wb_ack;
   logic            o_wb_err;
   logic [DW-1:0]   o_wb_data;

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
   );

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
   );
endinterface

// File: rtl/wb_fetch_responder.sv
// wb_fetch_responder
//   Read-only pipelined Wishbone responder serving instruction words.
//   Fixed LATENCY from accepting edge to registered ack/err, in order, with
//   at most MAXPEND requests outstanding. Writes and addresses beyond the
//   memory depth are answered with err; memory is never modified.
//   Ports:
//     i_clk    clock
//     i_reset  asynchronous, active-high reset
//     wb       wb_fetch_responder_if.slave bus bundle
//   Build option:
//     WB_FETCH_RESPONDER_STALL_INJECT_EN  adds LFSR-driven random stalls
//                                        (8-bit Fibonacci, taps 8,6,5,4).
module wb_fetch_responder #(
   parameter int    AW      = 28,
   parameter int    DW      = 32,
   parameter int    LGMEMSZ = 10,
   parameter int    LATENCY = 2,
   parameter int    MAXPEND = 4,
   parameter string HEXFILE = ""
) (
   input  logic                i_clk,
   input  logic                i_reset,
   wb_fetch_responder_if.slave wb
);
   localparam int PW    = $clog2(MAXPEND + 1);
   localparam int DEPTH = 1 << LGMEMSZ;

   logic [DW-1:0] mem [DEPTH] = '{default: '0};

   logic                accept;
   logic                bad_in;
   logic                stall;
   logic                resp;
   logic [LATENCY-1:0]  pipe_valid;
   logic [LATENCY-1:0]  pipe_bad;
   logic [LGMEMSZ-1:0]  pipe_addr [LATENCY];
   logic [PW-1:0]       pending;
   logic                ack_q;
   logic                err_q;
   logic [DW-1:0]       data_q;
   logic                unused_wb;

`ifdef WB_FETCH_RESPONDER_STALL_INJECT_EN
   logic [7:0] lfsr;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         lfsr <= 8'h01;
      else
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign stall = (pending == PW'(MAXPEND)) || (lfsr[1:0] == 2'b00);
`else
   assign stall = (pending == PW'(MAXPEND));
`endif

   assign accept    = wb.i_wb_cyc && wb.i_wb_stb && !stall;
   assign bad_in    = wb.i_wb_we || (wb.i_wb_addr[AW-1:LGMEMSZ] != '0);
   assign resp      = ack_q || err_q;
   assign unused_wb = ^{wb.i_wb_data, wb.i_wb_sel};

   // Valid bits carry the in-flight state; dropping cyc kills every slot.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pipe_valid <= '0;
      end else if (!wb.i_wb_cyc) begin
         pipe_valid <= '0;
      end else begin
         pipe_valid[0] <= accept;
         for (int unsigned i = 1; i < LATENCY; i++)
            pipe_valid[i] <= pipe_valid[i-1];
      end
   end

   // Payload is only meaningful alongside its valid bit, so it needs no reset.
   always_ff @(posedge i_clk) begin
      pipe_bad[0]  <= bad_in;
      pipe_addr[0] <= wb.i_wb_addr[LGMEMSZ-1:0];
      for (int unsigned i = 1; i < LATENCY; i++) begin
         pipe_bad[i]  <= pipe_bad[i-1];
         pipe_addr[i] <= pipe_addr[i-1];
      end
   end

   // Memory is read at the last stage straight into the response register,
   // so accept at edge N shows up after edge N+LATENCY.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         data_q <= '0;
      end else if (!wb.i_wb_cyc) begin
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         ack_q <= pipe_valid[LATENCY-1] && !pipe_bad[LATENCY-1];
         err_q <= pipe_valid[LATENCY-1] &&  pipe_bad[LATENCY-1];
         if (pipe_valid[LATENCY-1])
            data_q <= pipe_bad[LATENCY-1] ? '0 : mem[pipe_addr[LATENCY-1]];
      end
   end

   // Outstanding count: a request retires on the edge after its response.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         pending <= '0;
      else if (!wb.i_wb_cyc)
         pending <= '0;
      else if (accept && !resp)
         pending <= pending + PW'(1);
      else if (!accept && resp)
         pending <= pending - PW'(1);
   end

   assign wb.o_wb_stall = stall;
   assign wb.o_wb_ack   = ack_q;
   assign wb.o_wb_err   = err_q;
   assign wb.o_wb_data  = data_q;
endmodule

// File: tb/tb_wb_fetch_responder.sv
// tb_wb_fetch_responder
//   Two responders (LATENCY=2/MAXPEND=4 and LATENCY=4/MAXPEND=2) driven by
//   directed steps followed by random traffic. A response schedule keyed by
//   due cycle predicts ack/err/data/stall each cycle.
module tb_wb_fetch_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_fetch_responder_if #(.AW(28), .DW(32)) ifa ();
   wb_fetch_responder_if #(.AW(28), .DW(32)) ifb ();

   logic        cyc_d  [2];
   logic        stb_d  [2];
   logic        we_d   [2];
   logic [27:0] addr_d [2];

   assign ifa.i_wb_cyc  = cyc_d[0];
   assign ifa.i_wb_stb  = stb_d[0];
   assign ifa.i_wb_we   = we_d[0];
   assign ifa.i_wb_addr = addr_d[0];
   assign ifa.i_wb_data = 32'h0;
   assign ifa.i_wb_sel  = 4'hf;
   assign ifb.i_wb_cyc  = cyc_d[1];
   assign ifb.i_wb_stb  = stb_d[1];
   assign ifb.i_wb_we   = we_d[1];
   assign ifb.i_wb_addr = addr_d[1];
   assign ifb.i_wb_data = 32'h0;
   assign ifb.i_wb_sel  = 4'hf;

   logic        ack_o   [2];
   logic        err_o   [2];
   logic        stall_o [2];
   logic [31:0] data_o  [2];

   assign ack_o[0]   = ifa.o_wb_ack;
   assign err_o[0]   = ifa.o_wb_err;
   assign stall_o[0] = ifa.o_wb_stall;
   assign data_o[0]  = ifa.o_wb_data;
   assign ack_o[1]   = ifb.o_wb_ack;
   assign err_o[1]   = ifb.o_wb_err;
   assign stall_o[1] = ifb.o_wb_stall;
   assign data_o[1]  = ifb.o_wb_data;

   wb_fetch_responder #(
      .AW(28), .DW(32), .LGMEMSZ(10), .LATENCY(2), .MAXPEND(4)
   ) dut_a (
      .i_clk   (clk),
      .i_reset (rst),
      .wb      (ifa.slave)
   );

   wb_fetch_responder #(
      .AW(28), .DW(32), .LGMEMSZ(10), .LATENCY(4), .MAXPEND(2)
   ) dut_b (
      .i_clk   (clk),
      .i_reset (rst),
      .wb      (ifb.slave)
   );

   // Reference model
   int          lat [2] = '{2, 4};
   int          mp  [2] = '{4, 2};
   logic [31:0] mem_m [2][1024];
   bit          s_valid [2][16];
   bit          s_bad   [2][16];
   logic [31:0] s_data  [2][16];
   int          pend_m   [2] = '{0, 0};
   bit          prev_vis [2] = '{0, 0};
   bit          exp_ack  [2] = '{0, 0};
   bit          exp_err  [2] = '{0, 0};
   bit          acc_m    [2] = '{0, 0};
   logic [31:0] data_m   [2] = '{32'h0, 32'h0};

   int n_assert = 0;
   int n_fail   = 0;
   int cycle    = 0;

   task automatic chk(input string tag, input int d, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d cycle %0d: observed %h, expected %h",
                tag, d, cycle, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 2; d++) begin
         chk("ack",   d, {31'b0, ack_o[d]},   {31'b0, exp_ack[d]});
         chk("err",   d, {31'b0, err_o[d]},   {31'b0, exp_err[d]});
         chk("data",  d, data_o[d],           data_m[d]);
         chk("stall", d, {31'b0, stall_o[d]}, {31'b0, (pend_m[d] == mp[d])});
      end
   endtask

   // Predict the effect of the upcoming edge, take it, then compare.
   task automatic tick();
      int k;
      bit bad;
      k = cycle + 1;
      for (int i = 0; i < 2; i++) begin
         acc_m[i]   = 1'b0;
         exp_ack[i] = 1'b0;
         exp_err[i] = 1'b0;
         if (rst || !cyc_d[i]) begin
            for (int s = 0; s < 16; s++) s_valid[i][s] = 1'b0;
            pend_m[i] = 0;
            if (rst) data_m[i] = 32'h0;
         end else begin
            acc_m[i] = stb_d[i] && (pend_m[i] != mp[i]);
            bad = we_d[i] || (addr_d[i] >= 28'd1024);
            if (acc_m[i]) begin
               s_valid[i][(k + lat[i]) % 16] = 1'b1;
               s_bad[i][(k + lat[i]) % 16]   = bad;
               s_data[i][(k + lat[i]) % 16]  = bad ? 32'h0 : mem_m[i][addr_d[i][9:0]];
            end
            pend_m[i] = pend_m[i] + int'(acc_m[i]) - int'(prev_vis[i]);
            if (s_valid[i][k % 16]) begin
               s_valid[i][k % 16] = 1'b0;
               exp_ack[i] = !s_bad[i][k % 16];
               exp_err[i] =  s_bad[i][k % 16];
               data_m[i]  = s_data[i][k % 16];
            end
         end
         prev_vis[i] = exp_ack[i] || exp_err[i];
      end
      @(posedge clk);
      cycle++;
      #1;
      check_all();
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         cyc_d[d]  = 1'b0;
         stb_d[d]  = 1'b0;
         we_d[d]   = 1'b0;
         addr_d[d] = '0;
         for (int j = 0; j < 1024; j++) mem_m[d][j] = $urandom;
         mem_m[d][5] = 32'h12345678;
      end
      for (int j = 0; j < 1024; j++) begin
         dut_a.mem[j] = mem_m[0][j];
         dut_b.mem[j] = mem_m[1][j];
      end

      // Reset values
      #1;
      check_all();
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Single read of addr 5, ack two cycles after accept
      cyc_d[0] = 1'b1; stb_d[0] = 1'b1; addr_d[0] = 28'd5;
      tick();
      stb_d[0] = 1'b0;
      tick();
      tick();
      chk("t1_ack",  0, {31'b0, ack_o[0]}, 32'h1);
      chk("t1_data", 0, data_o[0], 32'h12345678);
      repeat (2) tick();
      cyc_d[0] = 1'b0;
      tick();

      // Back-to-back reads of 0..3
      cyc_d[0] = 1'b1; stb_d[0] = 1'b1;
      for (int a = 0; a < 4; a++) begin
         addr_d[0] = 28'(a);
         tick();
      end
      stb_d[0] = 1'b0;
      repeat (4) tick();
      cyc_d[0] = 1'b0;
      tick();

      // Stall pressure on the MAXPEND=2, LATENCY=4 instance
      begin
         int j;
         j = 0;
         cyc_d[1] = 1'b1; stb_d[1] = 1'b1;
         for (int t = 0; t < 40 && j < 4; t++) begin
            addr_d[1] = 28'(100 + j);
            tick();
            if (acc_m[1]) j++;
         end
         stb_d[1] = 1'b0;
         repeat (8) tick();
         chk("t3_stall_end", 1, {31'b0, stall_o[1]}, 32'h0);
         cyc_d[1] = 1'b0;
         tick();
      end

      // Write, then out-of-range read, then read-back of addr 0
      cyc_d[0] = 1'b1; stb_d[0] = 1'b1; we_d[0] = 1'b1; addr_d[0] = 28'd0;
      tick();
      we_d[0] = 1'b0; addr_d[0] = 28'd1024;
      tick();
      stb_d[0] = 1'b0;
      repeat (3) tick();
      stb_d[0] = 1'b1; addr_d[0] = 28'd0;
      tick();
      stb_d[0] = 1'b0;
      repeat (3) tick();
      cyc_d[0] = 1'b0;
      tick();

      // Abort with reads in flight, then a clean cycle reading addr 7
      cyc_d[0] = 1'b1; stb_d[0] = 1'b1;
      for (int a = 10; a < 13; a++) begin
         addr_d[0] = 28'(a);
         tick();
      end
      cyc_d[0] = 1'b0; stb_d[0] = 1'b0;
      repeat (3) tick();
      cyc_d[0] = 1'b1; stb_d[0] = 1'b1; addr_d[0] = 28'd7;
      tick();
      stb_d[0] = 1'b0;
      repeat (3) tick();

      // Asynchronous reset with two reads in flight
      stb_d[0] = 1'b1; addr_d[0] = 28'd20;
      tick();
      addr_d[0] = 28'd21;
      tick();
      stb_d[0] = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("t6_ack",   0, {31'b0, ack_o[0]},   32'h0);
      chk("t6_err",   0, {31'b0, err_o[0]},   32'h0);
      chk("t6_stall", 0, {31'b0, stall_o[0]}, 32'h0);
      chk("t6_data",  0, data_o[0],           32'h0);
      tick();
      tick();
      rst = 1'b0;
      repeat (4) tick();
      cyc_d[0] = 1'b0;
      tick();

      // Random traffic on both instances
      repeat (600) begin
         for (int d = 0; d < 2; d++) begin
            cyc_d[d]  = ($urandom % 10) != 0;
            stb_d[d]  = ($urandom % 10) < 6;
            we_d[d]   = ($urandom % 10) == 0;
            addr_d[d] = (($urandom % 8) == 0) ? 28'($urandom) : 28'($urandom % 1024);
         end
         tick();
      end
      for (int d = 0; d < 2; d++) begin
         cyc_d[d] = 1'b0;
         stb_d[d] = 1'b0;
      end
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
